// File: rtl/host_loader_if.sv
// host_loader_if: host command/data inputs and target-buffer write outputs.
//   master : host/collider side (drives GPIOcmd, GPIOdata, in_collision_state)
//   slave  : host_loader side (drives wr_*, GPIOack, load_count, load_done, addr_err)
interface host_loader_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 10
);
  logic [DATA_WIDTH-1:0]    GPIOcmd;
  logic [DATA_WIDTH-1:0]    GPIOdata;
  logic                     in_collision_state;
  logic                     wr_en;
  logic [1:0]               wr_sel;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     GPIOack;
  logic [ADDRESS_WIDTH:0]   load_count;
  logic                     load_done;
  logic                     addr_err;

  modport master (
    output GPIOcmd, GPIOdata, in_collision_state,
    input  wr_en, wr_sel, wr_addr, wr_data, GPIOack, load_count, load_done, addr_err
  );

  modport slave (
    input  GPIOcmd, GPIOdata, in_collision_state,
    output wr_en, wr_sel, wr_addr, wr_data, GPIOack, load_count, load_done, addr_err
  );
endinterface

// File: rtl/host_loader.sv
// host_loader: retires toggle-handshake write requests from a slow GPIO host
// into one of four target-buffer planes, stalling while the collider owns them.
//   clk, rst   : clock, asynchronous active-low reset
//   bus.slave  : GPIOcmd/GPIOdata/in_collision_state in;
//                wr_en/wr_sel/wr_addr/wr_data, GPIOack, load_count/load_done/addr_err out
module host_loader #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned DEPTH         = 1024
) (
  input  logic          clk,
  input  logic          rst,
  host_loader_if.slave  bus
);

  localparam int unsigned CNT_W = ADDRESS_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CAPTURE   = 3'd1,
    S_WAIT_FREE = 3'd2,
    S_WRITE     = 3'd3,
    S_ACK       = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic req_s1_q, req_s2_q, req_s3_q;
  logic en_s1_q, en_s2_q, en_s3_q;

  logic                     wr_en_q, wr_en_d;
  logic [1:0]               wr_sel_q, wr_sel_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     gpio_ack_q, gpio_ack_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     done_q, done_d;
  logic                     addr_err_q, addr_err_d;
  logic                     wr_ok_q, wr_ok_d;   // current transaction actually writes

  logic req_edge_c, en_rise_c, addr_ok_c;
  logic unused_cmd_bits;

  assign req_edge_c      = req_s2_q ^ req_s3_q;
  assign en_rise_c       = en_s2_q & ~en_s3_q;
  assign addr_ok_c       = ({1'b0, bus.GPIOcmd[ADDRESS_WIDTH-1:0]} < CNT_W'(DEPTH));
  assign unused_cmd_bits = ^bus.GPIOcmd;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; a req edge with load disabled is acked without a write
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (req_edge_c) state_d = en_s2_q ? S_CAPTURE : S_ACK;
      S_CAPTURE:   state_d = addr_ok_c ? S_WAIT_FREE : S_ACK;
      S_WAIT_FREE: if (!bus.in_collision_state) state_d = S_WRITE;
      S_WRITE:     state_d = S_ACK;
      S_ACK:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output logic; wr_en is registered on entry to WRITE so it is high during that state
  always_comb begin
    wr_en_d    = (state_q == S_WAIT_FREE) && !bus.in_collision_state;
    wr_sel_d   = wr_sel_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    gpio_ack_d = gpio_ack_q;
    count_d    = count_q;
    addr_err_d = addr_err_q;
    wr_ok_d    = wr_ok_q;
    unique case (state_q)
      S_IDLE: if (req_edge_c) wr_ok_d = 1'b0;
      S_CAPTURE: begin
        wr_ok_d = addr_ok_c;
        if (addr_ok_c) begin
          wr_sel_d  = bus.GPIOcmd[ADDRESS_WIDTH+1:ADDRESS_WIDTH];
          wr_addr_d = bus.GPIOcmd[ADDRESS_WIDTH-1:0];
          wr_data_d = bus.GPIOdata;
        end else begin
          addr_err_d = 1'b1;
        end
      end
      S_ACK: begin
        gpio_ack_d = req_s2_q;
        if (wr_ok_q && (count_q < CNT_W'(DEPTH))) count_d = count_q + CNT_W'(1);
      end
      default: ;
    endcase
    // A new load session starts on the synchronized enable rising
    if (en_rise_c) begin
      count_d    = '0;
      addr_err_d = 1'b0;
    end
    done_d = (count_d == CNT_W'(DEPTH));
  end

  // Synchronizers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_s1_q   <= 1'b0;
      req_s2_q   <= 1'b0;
      req_s3_q   <= 1'b0;
      en_s1_q    <= 1'b0;
      en_s2_q    <= 1'b0;
      en_s3_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      gpio_ack_q <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      wr_ok_q    <= 1'b0;
    end else begin
      req_s1_q   <= bus.GPIOcmd[DATA_WIDTH-2];
      req_s2_q   <= req_s1_q;
      req_s3_q   <= req_s2_q;
      en_s1_q    <= bus.GPIOcmd[DATA_WIDTH-1];
      en_s2_q    <= en_s1_q;
      en_s3_q    <= en_s2_q;
      wr_en_q    <= wr_en_d;
      wr_sel_q   <= wr_sel_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      gpio_ack_q <= gpio_ack_d;
      count_q    <= count_d;
      done_q     <= done_d;
      addr_err_q <= addr_err_d;
      wr_ok_q    <= wr_ok_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_sel     = wr_sel_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.GPIOack    = gpio_ack_q;
  assign bus.load_count = count_q;
  assign bus.load_done  = done_q;
  assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_host_loader.sv
// Bench for host_loader: host-side toggle handshake driver, write scoreboard
// fed at request time and drained by a wr_en monitor, session-level model.
module tb_host_loader;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1000;   // below 2**AW so out-of-range addresses are expressible

  typedef struct packed {
    logic [1:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  host_loader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  host_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_seen = 0;
  int last_wr_cyc = -1;
  exp_t exp_q[$];

  // host / reference model state
  logic en_lvl = 1'b1;
  logic req_lvl = 1'b0;
  int m_count = 0;
  bit m_err = 0;
  logic [1:0]    m_sel = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst && bus.wr_en) begin
      wr_seen++;
      last_wr_cyc = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got sel=%0d addr=%0d data=%h, expected no write",
                 bus.wr_sel, bus.wr_addr, bus.wr_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.wr_sel !== e.sel || bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
          n_bad++;
          $display("FAIL wr_payload: got sel=%0d addr=%0d data=%h, expected sel=%0d addr=%0d data=%h",
                   bus.wr_sel, bus.wr_addr, bus.wr_data, e.sel, e.addr, e.data);
        end
      end
    end
  end

  function automatic logic [DW-1:0] make_cmd(input logic [1:0] sel, input logic [AW-1:0] addr);
    logic [DW-1:0] c;
    c = '0;
    c[DW-1] = en_lvl;
    c[DW-2] = req_lvl;
    c[AW+1:AW] = sel;
    c[AW-1:0] = addr;
    return c;
  endfunction

  task automatic set_en(input logic v);
    @(negedge clk);
    if (v && !en_lvl) begin
      m_count = 0;
      m_err = 0;
    end
    en_lvl = v;
    bus.GPIOcmd[DW-1] = v;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_state();
    chk("load_count", bus.load_count, m_count);
    chk("load_done", bus.load_done, (m_count == DEPTH));
    chk("addr_err", bus.addr_err, m_err);
    chk("wr_sel_hold", bus.wr_sel, m_sel);
    chk("wr_addr_hold", bus.wr_addr, m_addr);
    chk("wr_data_hold", bus.wr_data, m_data);
  endtask

  // One host transaction; latency is counted from E0, the first edge seeing the new req
  task automatic txn(input logic [1:0] sel, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                     input bit timed, input int bound);
    int e0, ackc, w0;
    bit valid, got;
    exp_t e;
    valid = en_lvl && (int'(addr) < DEPTH);
    if (valid) begin
      e.sel = sel; e.addr = addr; e.data = data;
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_lvl = ~req_lvl;
    bus.GPIOcmd = make_cmd(sel, addr);
    bus.GPIOdata = data;
    e0 = cyc + 1;
    w0 = wr_seen;
    got = 0;
    ackc = 0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (bus.GPIOack === req_lvl) begin
        got = 1;
        ackc = cyc;
      end
    end
    chk("ack_seen", got, 1);
    if (en_lvl) begin
      if (valid) begin
        if (m_count < DEPTH) m_count++;
        m_sel = sel; m_addr = addr; m_data = data;
      end else begin
        m_err = 1;
      end
    end
    chk("writes_per_txn", wr_seen - w0, valid);
    chk("pending_writes", exp_q.size(), 0);
    if (timed && got) begin
      if (valid) chk("wr_latency", last_wr_cyc - e0, 4);
      chk("ack_latency", ackc - e0, !en_lvl ? 3 : (valid ? 6 : 4));
    end
    check_state();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, drop_c;
    bus.in_collision_state = 1'b0;
    bus.GPIOcmd = make_cmd(2'd0, '0);
    bus.GPIOdata = '0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_ack", bus.GPIOack, 0);
    check_state();
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // basic write with exact latency
    txn(2'd2, 10'd5, 32'h3F800000, 1, 100);

    // load disabled: acked, not written
    set_en(1'b0);
    txn(2'd1, 10'd3, 32'hDEADBEEF, 1, 100);
    set_en(1'b1);

    // out-of-range addresses
    txn(2'd0, 10'(DEPTH), 32'h12345678, 1, 100);
    txn(2'd3, 10'd1023, 32'h0BADF00D, 1, 100);
    txn(2'd1, 10'(DEPTH - 1), 32'hCAFE0001, 1, 100);

    // collider owns the buffers for 20 cycles
    bus.in_collision_state = 1'b1;
    w0 = wr_seen;
    drop_c = 0;
    fork
      txn(2'd3, 10'd77, 32'hA5A5A5A5, 0, 200);
      begin
        repeat (20) @(negedge clk);
        chk("coll_no_write", wr_seen - w0, 0);
        drop_c = cyc;
        bus.in_collision_state = 1'b0;
      end
    join
    chk("coll_release_latency", last_wr_cyc - drop_c, 1);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(DEPTH, 1023)) : AW'($urandom_range(0, DEPTH - 1));
      txn(2'($urandom_range(0, 3)), a, $urandom(), 1, 100);
    end

    // reset while waiting for the collider
    bus.in_collision_state = 1'b1;
    @(negedge clk);
    req_lvl = ~req_lvl;
    bus.GPIOcmd = make_cmd(2'd1, 10'd7);
    bus.GPIOdata = 32'h55AA55AA;
    repeat (8) @(negedge clk);
    w0 = wr_seen;
    #2 rst = 1'b0;
    #1;
    m_count = 0; m_err = 0; m_sel = '0; m_addr = '0; m_data = '0;
    chk("rst_async_wr_en", bus.wr_en, 0);
    chk("rst_async_ack", bus.GPIOack, 0);
    check_state();
    req_lvl = 1'b0;
    bus.GPIOcmd = make_cmd(2'd0, '0);
    bus.in_collision_state = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_no_write_after", wr_seen - w0, 0);
    chk("rst_ack_after", bus.GPIOack, 0);
    txn(2'd0, 10'd9, 32'h01020304, 1, 100);

    // full session fills every address, then saturates
    set_en(1'b0);
    set_en(1'b1);
    for (int i = 0; i < DEPTH; i++) txn(2'(i % 4), AW'(i), $urandom(), 1, 100);
    chk("full_count", bus.load_count, DEPTH);
    chk("full_done", bus.load_done, 1);
    txn(2'd2, 10'd0, 32'hFFFFFFFF, 1, 100);

    // new session clears counters
    set_en(1'b0);
    set_en(1'b1);
    check_state();
    chk("rerise_count", bus.load_count, 0);

    repeat (5) @(negedge clk);
    chk("final_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
